// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: credit-based read controller for a FIFO/LIFO with a 2-entry output buffer,
// delivered-word counter and running XOR checksum.
module fifo_rd_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Enable,
  input  logic             Empty,
  output logic             Rden,
  input  logic [WIDTH-1:0] Datain,
  output logic [WIDTH-1:0] Dout,
  output logic             Dvalid,
  input  logic             Dready,
  output logic             Busy,
  output logic [CNT_W-1:0] Wcount,
  output logic [WIDTH-1:0] Xsum
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  logic [1:0]       r_state, w_state_nxt, r_occ, w_occ_left;
  logic             r_inflight, w_pop;
  logic [WIDTH-1:0] r_head, r_tail, r_xsum;
  logic [CNT_W-1:0] r_wcount;
  assign Dout   = r_head;
  assign Dvalid = (r_occ != 2'd0);
  assign Busy   = (r_state != S_IDLE);
  assign Wcount = r_wcount;
  assign Xsum   = r_xsum;
  assign w_pop  = Dvalid && Dready;
  assign w_occ_left = r_occ - {1'b0, w_pop};
  // a read is allowed only if its word will still find a free slot when it lands
  assign Rden = (r_state == S_RUN) && !Empty && !Rst &&
                (({1'b0, r_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));
  always_comb
    w_state_nxt = (r_state == S_IDLE) ? (Enable ? S_RUN : S_IDLE) :
                  (r_state == S_RUN)  ? (Enable ? S_RUN : S_FLUSH) :
                  Enable ? S_RUN : (!r_inflight && r_occ == 2'd0) ? S_IDLE : S_FLUSH;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_wcount   <= '0;
      r_xsum     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= Rden;
      r_occ      <= w_occ_left + {1'b0, r_inflight};
      // head keeps the last popped word when the buffer drains
      if (r_inflight && w_occ_left == 2'd0)
        r_head <= Datain;
      else if (w_pop && r_occ == 2'd2)
        r_head <= r_tail;
      if (r_inflight && w_occ_left == 2'd1)
        r_tail <= Datain;
      if (w_pop) begin
        r_wcount <= r_wcount + 1'b1;
        r_xsum   <= r_xsum ^ r_head;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: scoreboard bench with a queue-based source FIFO model and random backpressure.
module tb_fifo_rd_ctrl;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Enable = 1'b0;
  logic        Empty;
  logic        Rden;
  logic [31:0] Datain = '0;
  logic [31:0] Dout;
  logic        Dvalid;
  logic        Dready = 1'b0;
  logic        Busy;
  logic [3:0]  Wcount;
  logic [31:0] Xsum;

  fifo_rd_ctrl #(.WIDTH(32), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Empty(Empty), .Rden(Rden),
    .Datain(Datain), .Dout(Dout), .Dvalid(Dvalid), .Dready(Dready),
    .Busy(Busy), .Wcount(Wcount), .Xsum(Xsum)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int n_reads = 0;
  logic src_clr = 1'b0;
  logic [31:0] exp_q [$];
  int m_cnt = 0;
  logic [31:0] m_xs = '0;
  logic stall = 1'b0;
  logic [31:0] st_dout = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // source FIFO: word appears on Datain the cycle after Rden
  assign Empty = (rd_ptr == wr_ptr);
  always @(posedge Clk) begin
    if (src_clr)
      rd_ptr <= wr_ptr;
    else if (Rden) begin
      Datain  <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
      n_reads <= n_reads + 1;
    end
  end

  always @(negedge Clk) begin
    if (Rst) begin
      chk("rden_in_reset", 32'(Rden), 32'd0);
      exp_q.delete();
      m_cnt = 0;
      m_xs = '0;
      stall = 1'b0;
    end else begin
      chk("rden_when_empty_or_idle", 32'(Rden && (Empty || !Busy)), 32'd0);
      if (stall) begin
        chk("stall_dvalid", 32'(Dvalid), 32'd1);
        chk("stall_dout", Dout, st_dout);
      end
      chk("wcount", 32'(Wcount), 32'(m_cnt % 16));
      chk("xsum", Xsum, m_xs);
      if (Dvalid && Dready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", Dout);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("dout", Dout, e);
          m_cnt++;
          m_xs ^= e;
        end
      end
      stall = Dvalid && !Dready;
      st_dout = Dout;
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [31:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  task automatic do_reset;
    Rst = 1'b1;
    src_clr = 1'b1;
    Enable = 1'b0;
    Dready = 1'b0;
    tick;
    Rst = 1'b0;
    src_clr = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick;
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && Busy; i++) tick;
    chk("busy_timeout", 32'(Busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int loaded;
    logic [31:0] x;
    logic [31:0] d;
    do_reset;
    @(negedge Clk);
    chk("reset_dvalid", 32'(Dvalid), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_dout", Dout, 32'd0);

    // basic stream
    tick;
    for (int i = 0; i < 5; i++) load(32'h11 + 32'(i));
    Dready = 1'b1;
    Enable = 1'b1;
    @(negedge Clk);
    chk("startup_rden_low", 32'(Rden), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick;
      @(negedge Clk);
      chk("basic_rden_high", 32'(Rden), 32'd1);
    end
    tick;
    @(negedge Clk);
    chk("basic_rden_done", 32'(Rden), 32'd0);
    repeat (3) tick;
    @(negedge Clk);
    chk("basic_wcount", 32'(Wcount), 32'd5);
    chk("basic_xsum", Xsum, 32'h11);
    chk("basic_all_out", 32'(exp_q.size()), 32'd0);
    Enable = 1'b0;
    wait_idle(6);

    // backpressure
    do_reset;
    for (int i = 0; i < 6; i++) load(32'h100 + 32'(i));
    r0 = n_reads;
    Enable = 1'b1;
    repeat (10) tick;
    @(negedge Clk);
    chk("bp_reads", 32'(n_reads - r0), 32'd2);
    chk("bp_dvalid", 32'(Dvalid), 32'd1);
    chk("bp_dout", Dout, 32'h100);
    Dready = 1'b1;
    wait_drain(20);
    @(negedge Clk);
    chk("bp_wcount", 32'(Wcount), 32'd6);

    // empty boundary
    do_reset;
    Dready = 1'b1;
    load(32'h55);
    r0 = n_reads;
    Enable = 1'b1;
    repeat (20) tick;
    @(negedge Clk);
    chk("empty_single_read", 32'(n_reads - r0), 32'd1);
    chk("empty_rden_low", 32'(Rden), 32'd0);
    load(32'h66);
    wait_drain(10);
    @(negedge Clk);
    chk("empty_wcount", 32'(Wcount), 32'd2);
    chk("empty_xsum", Xsum, 32'h33);

    // flush with Rden high and one word buffered
    do_reset;
    Dready = 1'b1;
    for (int i = 0; i < 8; i++) load(32'h200 + 32'(i));
    Enable = 1'b1;
    repeat (3) tick;
    @(negedge Clk);
    chk("flush_pre_rden", 32'(Rden), 32'd1);
    chk("flush_pre_dvalid", 32'(Dvalid), 32'd1);
    r0 = n_reads;
    Enable = 1'b0;
    wait_idle(4);
    @(negedge Clk);
    chk("flush_reads", 32'(n_reads - r0), 32'd1);
    chk("flush_left_unread", 32'(exp_q.size()), 32'd5);
    chk("flush_wcount", 32'(Wcount), 32'd3);

    // reset mid-operation
    do_reset;
    Dready = 1'b1;
    for (int i = 0; i < 3; i++) load(32'h300 + 32'(i));
    Enable = 1'b1;
    wait_drain(10);
    @(negedge Clk);
    chk("rstmid_pre_wcount", 32'(Wcount), 32'd3);
    Dready = 1'b0;
    for (int i = 0; i < 4; i++) load(32'h3A0 + 32'(i));
    for (int i = 0; i < 6 && !Dvalid; i++) tick;
    chk("rstmid_dvalid", 32'(Dvalid), 32'd1);
    Rst = 1'b1;
    src_clr = 1'b1;
    tick;
    Rst = 1'b0;
    src_clr = 1'b0;
    @(negedge Clk);
    chk("rstmid_dvalid0", 32'(Dvalid), 32'd0);
    chk("rstmid_wcount0", 32'(Wcount), 32'd0);
    chk("rstmid_xsum0", Xsum, 32'd0);
    chk("rstmid_rden0", 32'(Rden), 32'd0);
    chk("rstmid_busy0", 32'(Busy), 32'd0);
    load(32'h3B0);
    load(32'h3B1);
    Dready = 1'b1;
    wait_drain(10);
    @(negedge Clk);
    chk("rstmid_after_wcount", 32'(Wcount), 32'd2);

    // wrap with random data and random backpressure
    do_reset;
    Enable = 1'b1;
    x = '0;
    loaded = 0;
    for (int c = 0; c < 400 && (loaded < 17 || exp_q.size() != 0); c++) begin
      if (loaded < 17 && $urandom_range(0, 2) == 0) begin
        d = $urandom;
        load(d);
        x ^= d;
        loaded++;
      end
      Dready = 1'($urandom_range(0, 1));
      tick;
    end
    chk("wrap_loaded", 32'(loaded), 32'd17);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);
    @(negedge Clk);
    chk("wrap_wcount", 32'(Wcount), 32'd1);
    chk("wrap_xsum", Xsum, x);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
